countdown_timer: RTL

Down-counting counterpart to the stopwatch: loads a packed {min, sec, msec_10} preset and decrements it every 10 ms tick to zero, then flags expiry. Sits beside the stopwatch in the timer IP. Shares the same packed 24-bit time format and 2-bit run/hold/clear command encoding, so software drives both blocks identically. A stop-at-zero done flag serves interrupt or LED logic.

---
 rtl/countdown_timer.sv | 112 +++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loads a {min, sec, msec_10} preset and counts it down
// in 10 ms ticks to zero, then raises a sticky expired flag and a done pulse.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cmd,
    input  logic [23:0] load_value,
    output logic [23:0] timer,
    output logic        running,
    output logic        expired,
    output logic        done
);

    localparam logic [1:0]  CMD_RUN   = 2'd1;
    localparam logic [1:0]  CMD_LOAD  = 2'd2;
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    logic [31:0] clk_cnt;
    logic [7:0]  min;
    logic [7:0]  sec;
    logic [7:0]  cs;

    logic [7:0]  min_dec;
    logic [7:0]  sec_dec;
    logic [7:0]  cs_dec;
    logic [7:0]  min_ld;
    logic [7:0]  sec_ld;
    logic [7:0]  cs_ld;
    logic        is_zero;
    logic        last_step;
    logic        tick;
    logic        run_cmd;
    logic        load_cmd;

    assign run_cmd   = (cmd == CMD_RUN);
    assign load_cmd  = (cmd == CMD_LOAD);
    assign is_zero   = (min == 8'd0) && (sec == 8'd0) && (cs == 8'd0);
    assign last_step = (min == 8'd0) && (sec == 8'd0) && (cs == 8'd1);
    assign tick      = (clk_cnt == TICK_LAST);

    assign min_ld = (load_value[23:16] > 8'd99) ? 8'd99 : load_value[23:16];
    assign sec_ld = (load_value[15:8]  > 8'd59) ? 8'd59 : load_value[15:8];
    assign cs_ld  = (load_value[7:0]   > 8'd99) ? 8'd99 : load_value[7:0];

    // Borrow ripples cs -> sec -> min; min never underflows since
    // a step is only taken while the timer is non-zero.
    always_comb begin
        cs_dec  = cs - 8'd1;
        sec_dec = sec;
        min_dec = min;
        if (cs == 8'd0) begin
            cs_dec = 8'd99;
            if (sec == 8'd0) begin
                sec_dec = 8'd59;
                min_dec = min - 8'd1;
            end else begin
                sec_dec = sec - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_cnt <= 32'd0;
            min     <= 8'd0;
            sec     <= 8'd0;
            cs      <= 8'd0;
            expired <= 1'b0;
            done    <= 1'b0;
            running <= 1'b0;
        end else begin
            done    <= 1'b0;
            running <= run_cmd && !is_zero;
            unique case (1'b1)
                load_cmd: begin
                    clk_cnt <= 32'd0;
                    min     <= min_ld;
                    sec     <= sec_ld;
                    cs      <= cs_ld;
                    expired <= 1'b0;
                end
                run_cmd: begin
                    if (is_zero) begin
                        clk_cnt <= 32'd0;
                        if (!expired) begin
                            expired <= 1'b1;
                            done    <= 1'b1;
                        end
                    end else if (tick) begin
                        clk_cnt <= 32'd0;
                        min     <= min_dec;
                        sec     <= sec_dec;
                        cs      <= cs_dec;
                        if (last_step) begin
                            expired <= 1'b1;
                            done    <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign timer = {min, sec, cs};

endmodule
